inst_fetch: RTL and testbench

//  Fetch stage wrapped around the PC register: reads current pc, issues instruction-memory

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 49 ++++
 rtl/inst_fetch.sv | 141 ++++++++++++++
 tb/tb_inst_fetch.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: FSM states, queue entry layout, NOP encoding.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} entries; flush empties it in one cycle.
// Latency: push at edge t is visible on head_dat after edge t (registered storage).
// Backpressure: push accepted when not full or when a pop happens the same cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage around the PC register: one outstanding imem request, {pc,inst} queue to decode.
// Latency: rvalid at cycle t gives out_valid at t+1; FETCH_PERF_EN adds perf counter outputs.
// Backpressure: a granted request reserves a queue slot; no request is issued into a full queue.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int          DEPTH = 2,
    parameter logic [31:0] NOP   = NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] pc_din,
    output logic        pc_wen,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t state, state_nxt;
    logic [31:0]  req_pc;
    logic         req_pc_ld;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    logic [CW-1:0] count;
    logic         slot_after_push;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    assign pop             = !empty && out_ready;
    assign push            = (state == WAIT) && imem_rvalid && !redirect_valid;
    assign push_entry      = '{pc: req_pc, inst: imem_rdata};
    // After this push, a slot is still free if decode pops now or the queue had two spare.
    assign slot_after_push = pop || (count < CW'(DEPTH - 1));

    assign out_valid = !empty;
    assign out_pc    = empty ? 32'h0 : head.pc;
    assign out_inst  = empty ? NOP : head.inst;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .flush    (redirect_valid),
        .head_dat (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        imem_addr = 32'h0;
        pc_wen    = 1'b0;
        pc_din    = 32'h0;
        req_pc_ld = 1'b0;
        case (state)
            IDLE: if (!full && !redirect_valid) state_nxt = REQ;
            REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc;
                if (imem_gnt) begin
                    req_pc_ld = 1'b1;
                    pc_wen    = 1'b1;
                    pc_din    = pc + 32'd4;
                    state_nxt = redirect_valid ? DROP : WAIT;
                end else if (redirect_valid) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (imem_rvalid)
                    state_nxt = (!redirect_valid && slot_after_push) ? REQ : IDLE;
                else if (redirect_valid)
                    state_nxt = DROP;
            end
            DROP: if (imem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (redirect_valid) begin
            pc_wen = 1'b1;
            pc_din = align_pc(redirect_pc);
        end
        // Keep the PC register and memory untouched while reset is asserted.
        if (rst) begin
            imem_req  = 1'b0;
            imem_addr = 32'h0;
            pc_wen    = 1'b0;
            pc_din    = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            req_pc <= 32'h0;
        end else begin
            state <= state_nxt;
            if (req_pc_ld) req_pc <= pc;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 32'h0;
            perf_stall_cnt <= 32'h0;
            perf_flush_cnt <= 32'h0;
        end else begin
            if (push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (((state == REQ) && !imem_gnt) || full) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: bench-owned PC register, randomized memory responder and an
// expected-output queue of {pc, inst} built from grants, responses and redirects.
module tb_inst_fetch;
    import fetch_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'h0;
    logic [31:0] pc_din;
    logic        pc_wen;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    inst_fetch #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_din         (pc_din),
        .pc_wen         (pc_wen),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Memory responder and expected-output model
    bit          in_rst = 1'b1;
    bit          mem_busy = 1'b0;
    bit          live = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr_q = 32'h0;
    logic [31:0] mem_data = 32'h0;
    logic [31:0] data_q[$];
    logic [63:0] exp_q[$];
    int gnt_pct = 100, lat_min = 1, lat_max = 1, ready_pct = 100, hold_gnt = 0;
    int pops = 0, gnts = 0;

    logic        s_req, s_gnt, s_wen, s_ovalid, s_pop, s_busy;
    logic [31:0] s_addr, s_din, s_oinst;

    task automatic cycle(input bit redir, input logic [31:0] rpc);
        logic        exp_wen;
        logic [31:0] exp_din;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = ($urandom_range(0, 99) < ready_pct);
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = $urandom;
        #1;
        if (mem_busy && mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data;
        end else if (!mem_busy && imem_req) begin
            if (hold_gnt > 0) hold_gnt--;
            else if ($urandom_range(0, 99) < gnt_pct) imem_gnt = 1'b1;
        end
        #1;
        s_req = imem_req; s_addr = imem_addr; s_gnt = imem_gnt; s_wen = pc_wen; s_din = pc_din;
        s_ovalid = out_valid; s_oinst = out_inst; s_pop = out_valid && out_ready; s_busy = mem_busy;
        if (!in_rst) begin
            tests++;
            if (out_valid !== (exp_q.size() != 0)) begin
                fails++;
                $display("FAIL out_valid: got %0b want %0b", out_valid, exp_q.size() != 0);
            end
            if (exp_q.size() != 0) begin
                tests++;
                if ({out_pc, out_inst} !== exp_q[0]) begin
                    fails++;
                    $display("FAIL head: got %h/%h want %h", out_pc, out_inst, exp_q[0]);
                end
            end else begin
                tests++;
                if (out_inst !== NOP_INST || out_pc !== 32'h0) begin
                    fails++;
                    $display("FAIL empty_out: got pc %h inst %h want 0/%h", out_pc, out_inst, NOP_INST);
                end
            end
            exp_wen = imem_gnt || redir;
            exp_din = redir ? (rpc & 32'hFFFF_FFFC) : pc + 32'd4;
            tests++;
            if (pc_wen !== exp_wen || (exp_wen && pc_din !== exp_din)) begin
                fails++;
                $display("FAIL next_pc: got wen %0b din %h want wen %0b din %h", pc_wen, pc_din, exp_wen, exp_din);
            end
            if (imem_req) begin
                tests++;
                if (imem_addr !== pc) begin
                    fails++;
                    $display("FAIL imem_addr: got %h want %h", imem_addr, pc);
                end
            end
            if (s_pop && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                pops++;
            end
            if (redir) begin
                exp_q.delete();
                live = 1'b0;
            end
        end
        if (imem_rvalid) begin
            if (live && !redir && !in_rst) begin
                exp_q.push_back({mem_addr_q, mem_data});
                tests++;
                if (exp_q.size() > DEPTH) begin
                    fails++;
                    $display("FAIL overflow: got %0d entries want <= %0d", exp_q.size(), DEPTH);
                end
            end
            mem_busy = 1'b0;
            live     = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
        end
        if (imem_gnt) begin
            gnts++;
            mem_busy   = 1'b1;
            mem_cnt    = int'($urandom_range(lat_min, lat_max)) - 1;
            mem_addr_q = imem_addr;
            mem_data   = (data_q.size() != 0) ? data_q.pop_front() : $urandom;
            live       = !redir && !in_rst;
        end
        @(posedge clk);
        #1;
        if (s_wen) pc = s_din;
        @(negedge clk);
    endtask

    task automatic do_reset(input bit drain);
        rst = 1'b1; in_rst = 1'b1;
        cycle(1'b0, 32'h0);
        cycle(1'b0, 32'h0);
        if (drain)
            for (int i = 0; i < 10 && mem_busy; i++) cycle(1'b0, 32'h0);
        rst = 1'b0; in_rst = 1'b0;
        exp_q.delete(); data_q.delete();
        live = 1'b0; hold_gnt = 0;
    endtask

    task automatic check_reset_out(input string name);
        redirect_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== NOP_INST) begin
            fails++;
            $display("FAIL %s_queue: got v %0b pc %h inst %h want 0/0/%h", name, out_valid, out_pc, out_inst, NOP_INST);
        end
        tests++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            fails++;
            $display("FAIL %s_imem: got req %0b addr %h want 0/0", name, imem_req, imem_addr);
        end
        tests++;
        if (pc_wen !== 1'b0 || pc_din !== 32'h0) begin
            fails++;
            $display("FAIL %s_pc: got wen %0b din %h want 0/0", name, pc_wen, pc_din);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        check_reset_out("reset");
    endtask

    task automatic test_basic();
        do_reset(1'b1);
        pc = 32'h0000_2FFC; lat_min = 1; lat_max = 1; gnt_pct = 100; ready_pct = 100;
        data_q.push_back(32'h0050_0293);
        cycle(1'b0, 32'h0);
        cycle(1'b0, 32'h0);
        tests++;
        if (!(s_req && s_gnt && s_addr === 32'h2FFC && s_wen && s_din === 32'h3000)) begin
            fails++;
            $display("FAIL basic_gnt: got req %0b gnt %0b addr %h wen %0b din %h want 1/1/2ffc/1/3000",
                     s_req, s_gnt, s_addr, s_wen, s_din);
        end
        cycle(1'b0, 32'h0);
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h2FFC || out_inst !== 32'h0050_0293) begin
            fails++;
            $display("FAIL basic_out: got v %0b pc %h inst %h want 1/2ffc/00500293", out_valid, out_pc, out_inst);
        end
    endtask

    task automatic test_full_queue();
        int g0;
        bit req_seen;
        do_reset(1'b1);
        pc = 32'h0000_0100; lat_min = 1; lat_max = 1; gnt_pct = 100; ready_pct = 0;
        data_q.push_back(32'h00A0_0093);
        data_q.push_back(32'h0010_0113);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0);
        req_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0);
            if (s_req) req_seen = 1'b1;
        end
        tests++;
        if (req_seen || !s_ovalid) begin
            fails++;
            $display("FAIL full_stall: got req_seen %0b out_valid %0b want 0/1", req_seen, s_ovalid);
        end
        ready_pct = 100;
        cycle(1'b0, 32'h0);
        tests++;
        if (!s_pop || s_oinst !== 32'h00A0_0093) begin
            fails++;
            $display("FAIL full_pop1: got pop %0b inst %h want 1/00a00093", s_pop, s_oinst);
        end
        cycle(1'b0, 32'h0);
        tests++;
        if (!s_pop || s_oinst !== 32'h0010_0113) begin
            fails++;
            $display("FAIL full_pop2: got pop %0b inst %h want 1/00100113", s_pop, s_oinst);
        end
        g0 = gnts;
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0);
        tests++;
        if (gnts == g0) begin
            fails++;
            $display("FAIL full_resume: got %0d grants want > 0", gnts - g0);
        end
    endtask

    task automatic test_redirect_wait();
        bit found;
        do_reset(1'b1);
        pc = 32'h0000_0200; lat_min = 3; lat_max = 3; gnt_pct = 100; ready_pct = 0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle(1'b0, 32'h0);
            if (exp_q.size() == 1 && mem_busy) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL redir_setup: got no WAIT with one queued entry want one");
        end
        cycle(1'b1, 32'h0000_4002);
        tests++;
        if (!s_wen || s_din !== 32'h4000) begin
            fails++;
            $display("FAIL redir_pc: got wen %0b din %h want 1/4000", s_wen, s_din);
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL redir_flush: got out_valid %0b want 0", out_valid);
        end
        ready_pct = 100;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b0, 32'h0);
            if (s_req) begin
                found = 1'b1;
                tests++;
                if (s_addr !== 32'h4000 || s_busy) begin
                    fails++;
                    $display("FAIL redir_refetch: got addr %h busy %0b want 4000/0", s_addr, s_busy);
                end
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL redir_timeout: got no request want one");
        end
    endtask

    task automatic test_redirect_gnt();
        bit found;
        do_reset(1'b1);
        pc = 32'h0000_0500; lat_min = 2; lat_max = 2; gnt_pct = 100; ready_pct = 100;
        cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h0000_8000);
        tests++;
        if (!s_gnt || !s_wen || s_din !== 32'h8000) begin
            fails++;
            $display("FAIL rgnt_pc: got gnt %0b wen %0b din %h want 1/1/8000", s_gnt, s_wen, s_din);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b0, 32'h0);
            if (s_req) begin
                found = 1'b1;
                tests++;
                if (s_addr !== 32'h8000 || s_busy) begin
                    fails++;
                    $display("FAIL rgnt_drop: got addr %h busy %0b want 8000/0", s_addr, s_busy);
                end
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL rgnt_timeout: got no request want one");
        end
    endtask

    task automatic test_wrap_reset();
        int  g0;
        bit  early_valid;
        do_reset(1'b1);
        pc = 32'hFFFF_FFFC; lat_min = 6; lat_max = 6; gnt_pct = 100; ready_pct = 100;
        cycle(1'b0, 32'h0);
        cycle(1'b0, 32'h0);
        tests++;
        if (!s_gnt || !s_wen || s_din !== 32'h0) begin
            fails++;
            $display("FAIL wrap_pc: got gnt %0b wen %0b din %h want 1/1/0", s_gnt, s_wen, s_din);
        end
        cycle(1'b0, 32'h0);
        do_reset(1'b0);
        check_reset_out("midreset");
        g0 = gnts;
        early_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 32'h0);
            if (gnts == g0 && s_ovalid) early_valid = 1'b1;
        end
        tests++;
        if (early_valid || gnts == g0) begin
            fails++;
            $display("FAIL late_rvalid: got early_valid %0b grants %0d want 0/>0", early_valid, gnts - g0);
        end
    endtask

    task automatic test_random();
        int p0;
        do_reset(1'b1);
        pc = $urandom & 32'hFFFF_FFFC;
        lat_min = 1; lat_max = 4; gnt_pct = 60; ready_pct = 50;
        p0 = pops;
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 99) < 4, $urandom);
        tests++;
        if (pops - p0 < 100) begin
            fails++;
            $display("FAIL random_progress: got %0d pops want >= 100", pops - p0);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset(1'b1);
        pc = 32'h0000_1000; lat_min = 1; lat_max = 1; gnt_pct = 100; ready_pct = 100;
        hold_gnt = 2;
        for (int i = 0; i < 40 && perf_fetch_cnt != 32'd3; i++) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h0000_2000);
        tests++;
        if (perf_fetch_cnt !== 32'd3 || perf_stall_cnt !== 32'd2 || perf_flush_cnt !== 32'd1) begin
            fails++;
            $display("FAIL perf: got %0d/%0d/%0d want 3/2/1", perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_full_queue();
        test_redirect_wait();
        test_redirect_gnt();
        test_wrap_reset();
        test_random();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion want finish before 500000ns");
        $fatal(1, "bench time limit");
    end

endmodule
